// File: rtl/uart_fifo_pkg.sv
// Shared constants and the pointer-status record for the UART buffer FIFO.
// LEVEL_W covers the largest legal depth (256), so one struct type serves every build.
package uart_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;
    localparam int LEVEL_W       = 9;

    typedef struct packed {
        logic               full;
        logic               empty;
        logic [LEVEL_W-1:0] level;
    } ptr_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH flop storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately never reset; occupancy lives in the pointer logic.
module uart_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_buffer_fifo.sv
// First-word-fall-through UART buffer FIFO with registered full/empty/level and a watermark.
// Define UART_FIFO_ERR_EN to add the sticky ovf_o/udf_o error flags.
module uart_buffer_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [CW-1:0]    thresh_i,
`ifdef UART_FIFO_ERR_EN
    output logic             ovf_o,
    output logic             udf_o,
`endif
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    level_o,
    output logic             wmark_o
);

    logic [CW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
    ptr_status_t      status_q, status_d;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] mem_rdata;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = re_i && !status_q.empty;
    assign push_ok = we_i && (!status_q.full || pop_ok);

    always_comb begin
        wr_next         = wr_ptr + CW'(push_ok);
        rd_next         = rd_ptr + CW'(pop_ok);
        status_d.level  = status_q.level;
        if (push_ok && !pop_ok) begin
            status_d.level = status_q.level + LEVEL_W'(1);
        end else if (pop_ok && !push_ok) begin
            status_d.level = status_q.level - LEVEL_W'(1);
        end
        status_d.empty  = (wr_next == rd_next);
        status_d.full   = (wr_next[AW-1:0] == rd_next[AW-1:0]) && (wr_next[AW] != rd_next[AW]);
        if (clr_i) begin
            wr_next  = '0;
            rd_next  = '0;
            status_d = '{full: 1'b0, empty: 1'b1, level: '0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            status_q <= '{full: 1'b0, empty: 1'b1, level: '0};
        end else begin
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            status_q <= status_d;
        end
    end

`ifdef UART_FIFO_ERR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else if (clr_i) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (we_i && !push_ok) begin
                ovf_o <= 1'b1;
            end
            if (re_i && status_q.empty) begin
                udf_o <= 1'b1;
            end
        end
    end
`endif

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk_i),
        .we    (push_ok && !clr_i),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata_i),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign full_o  = status_q.full;
    assign empty_o = status_q.empty;
    assign level_o = status_q.level[CW-1:0];
    assign rdata_o = status_q.empty ? '0 : mem_rdata;
    assign wmark_o = (thresh_i != '0) && (status_q.level >= LEVEL_W'(thresh_i));

endmodule

// File: tb/tb_uart_buffer_fifo.sv
// Directed testbench for uart_buffer_fifo (DEPTH=16, WIDTH=8): a vector table plus
// hand-written fill/drain, wrap, flush and reset sequences. Flag checks follow UART_FIFO_ERR_EN.
module tb_uart_buffer_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int CW    = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clr_i = 1'b0;
    logic             we_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic             re_i = 1'b0;
    logic [CW-1:0]    thresh_i = '0;
    logic [WIDTH-1:0] rdata_o;
    logic             full_o, empty_o, wmark_o;
    logic [CW-1:0]    level_o;
`ifdef UART_FIFO_ERR_EN
    logic             ovf_o, udf_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic             clr;
        logic             we;
        logic             re;
        logic [WIDTH-1:0] wdata;
        logic [CW-1:0]    thresh;
        logic [WIDTH-1:0] exp_rdata;
        logic             exp_full;
        logic             exp_empty;
        logic [CW-1:0]    exp_level;
        logic             exp_wmark;
    } vec_t;

    vec_t vecs [15];

    uart_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_i),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .re_i     (re_i),
        .thresh_i (thresh_i),
`ifdef UART_FIFO_ERR_EN
        .ovf_o    (ovf_o),
        .udf_o    (udf_o),
`endif
        .rdata_o  (rdata_o),
        .full_o   (full_o),
        .empty_o  (empty_o),
        .level_o  (level_o),
        .wmark_o  (wmark_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
    task automatic applyStimulus(input logic clr, input logic we, input logic [WIDTH-1:0] wdata,
                                 input logic re);
        clr_i   = clr;
        we_i    = we;
        wdata_i = wdata;
        re_i    = re;
        @(posedge clk_i);
        #1;
        clr_i = 1'b0;
        we_i  = 1'b0;
        re_i  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] rdata, input logic full,
                               input logic empty, input logic [CW-1:0] level, input logic wmark);
        vectors++;
        if (rdata_o !== rdata || full_o !== full || empty_o !== empty ||
            level_o !== level || wmark_o !== wmark) begin
            miscompares++;
            $display("[TB] FAIL %s: actual rdata=%h full=%b empty=%b level=%0d wmark=%b, required rdata=%h full=%b empty=%b level=%0d wmark=%b",
                     name, rdata_o, full_o, empty_o, level_o, wmark_o,
                     rdata, full, empty, level, wmark);
        end
    endtask

`ifdef UART_FIFO_ERR_EN
    task automatic checkFlags(input string name, input logic ovf, input logic udf);
        vectors++;
        if (ovf_o !== ovf || udf_o !== udf) begin
            miscompares++;
            $display("[TB] FAIL %s: actual ovf=%b udf=%b, required ovf=%b udf=%b",
                     name, ovf_o, udf_o, ovf, udf);
        end
    endtask
`endif

    task automatic doReset();
        rst_ni  = 1'b0;
        clr_i   = 1'b0;
        we_i    = 1'b0;
        re_i    = 1'b0;
        wdata_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //         clr we re wdata  th  rdata  full empty lvl wmark
        vecs[0]  = '{0, 0, 1, 8'h00, 4, 8'h00, 0, 1, 0, 0};
        vecs[1]  = '{0, 1, 0, 8'h11, 4, 8'h11, 0, 0, 1, 0};
        vecs[2]  = '{0, 1, 0, 8'h22, 4, 8'h11, 0, 0, 2, 0};
        vecs[3]  = '{0, 1, 0, 8'h33, 4, 8'h11, 0, 0, 3, 0};
        vecs[4]  = '{0, 1, 0, 8'h44, 4, 8'h11, 0, 0, 4, 1};
        vecs[5]  = '{0, 0, 1, 8'h00, 4, 8'h22, 0, 0, 3, 0};
        vecs[6]  = '{0, 1, 1, 8'h55, 4, 8'h33, 0, 0, 3, 0};
        vecs[7]  = '{0, 0, 0, 8'h00, 3, 8'h33, 0, 0, 3, 1};
        vecs[8]  = '{0, 0, 0, 8'h00, 0, 8'h33, 0, 0, 3, 0};
        vecs[9]  = '{0, 0, 1, 8'h00, 0, 8'h44, 0, 0, 2, 0};
        vecs[10] = '{0, 0, 1, 8'h00, 0, 8'h55, 0, 0, 1, 0};
        vecs[11] = '{0, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0};
        vecs[12] = '{0, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 0};
        vecs[13] = '{0, 1, 0, 8'h66, 1, 8'h66, 0, 0, 1, 1};
        vecs[14] = '{1, 1, 0, 8'h77, 1, 8'h00, 0, 1, 0, 0};

        // Reset state and the vector table.
        thresh_i = 4;
        doReset();
        checkOutput("reset_state", 8'h00, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int v = 0; v < 15; v++) begin
            thresh_i = vecs[v].thresh;
            applyStimulus(vecs[v].clr, vecs[v].we, vecs[v].wdata, vecs[v].re);
            checkOutput($sformatf("table_%0d", v), vecs[v].exp_rdata, vecs[v].exp_full,
                        vecs[v].exp_empty, vecs[v].exp_level, vecs[v].exp_wmark);
        end

        // Pop on empty is ignored and does not move the read pointer.
        thresh_i = 0;
        doReset();
        applyStimulus(1'b0, 1'b0, 8'hC3, 1'b1);
        checkOutput("pop_empty", 8'h00, 1'b0, 1'b1, 5'd0, 1'b0);
`ifdef UART_FIFO_ERR_EN
        checkFlags("pop_empty_flags", 1'b0, 1'b1);
`endif
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
        checkOutput("push_after_underflow", 8'h3C, 1'b0, 1'b0, 5'd1, 1'b0);

        // Fill to full, drop a 17th push, drain in order.
        doReset();
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
            checkOutput($sformatf("fill_%0d", i), 8'h01, i == DEPTH, 1'b0, 5'(i), 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b0);
        checkOutput("push_when_full", 8'h01, 1'b1, 1'b0, 5'd16, 1'b0);
`ifdef UART_FIFO_ERR_EN
        checkFlags("overflow_flag", 1'b1, 1'b0);
`endif
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("drain_%0d", i), (i < DEPTH) ? 8'(i + 1) : 8'h00,
                        1'b0, i == DEPTH, 5'(DEPTH - i), 1'b0);
        end

        // Simultaneous push and pop while full.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
        end
        checkOutput("refill", 8'h01, 1'b1, 1'b0, 5'd16, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1);
        checkOutput("push_pop_full", 8'h02, 1'b1, 1'b0, 5'd16, 1'b0);
        for (int k = 1; k <= DEPTH; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("drain_aa_%0d", k),
                        (k < 15) ? 8'(k + 2) : ((k == 15) ? 8'hAA : 8'h00),
                        1'b0, k == DEPTH, 5'(DEPTH - k), 1'b0);
        end

        // Steady level of 5 across pointer wrap.
        doReset();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
        end
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b0, 1'b1, 8'(6 + c), 1'b1);
            checkOutput($sformatf("wrap_%0d", c), 8'(c + 2), 1'b0, 1'b0, 5'd5, 1'b0);
        end

        // Flush at level 9 with overflow set; push in the same cycle is ignored.
        doReset();
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("level_9", 8'h08, 1'b0, 1'b0, 5'd9, 1'b0);
`ifdef UART_FIFO_ERR_EN
        checkFlags("level_9_flags", 1'b1, 1'b0);
`endif
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
        checkOutput("clear_with_push", 8'h00, 1'b0, 1'b1, 5'd0, 1'b0);
`ifdef UART_FIFO_ERR_EN
        checkFlags("clear_flags", 1'b0, 1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("after_clear", 8'h00, 1'b0, 1'b1, 5'd0, 1'b0);

        // Asynchronous reset mid-burst, then first push after release.
        thresh_i = 2;
        applyStimulus(1'b0, 1'b1, 8'h21, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h23, 1'b0);
        checkOutput("pre_reset", 8'h21, 1'b0, 1'b0, 5'd3, 1'b1);
        we_i    = 1'b1;
        wdata_i = 8'h24;
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 1'b0, 1'b1, 5'd0, 1'b0);
`ifdef UART_FIFO_ERR_EN
        checkFlags("async_reset_flags", 1'b0, 1'b0);
`endif
        we_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
        checkOutput("first_push_after_reset", 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
